rms_sqrt_arbiter: RTL and testbench
===================================

# rms_sqrt_arbiter

Round-robin arbiter that shares one `non_restoring_sqrt` core between `N_CH` RMS channels.
- Accepts one radicand per channel through a valid/ready handshake and drives the core one operation at a time.
- Returns each root on a single result port, tagged with the channel index.
- Resolves zero radicands locally, because the core never produces `o_data_valid` for zero.
- Sits between the per-channel mean-square accumulators and the RMS output registers.

## Interface
- `N_CH`, 4: number of requesting channels (2..16).
- `INOUT_WIDTH`, 16: root width; the radicand is `2*INOUT_WIDTH` bits.
- `TIMEOUT_CYCLES`, `4*INOUT_WIDTH`: watchdog limit, used only with `RMS_SQRT_ARB_TIMEOUT_EN`.
- `aclk`  in  1  clock; all logic on the rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `s_radicand`  in  `N_CH*2*INOUT_WIDTH`  packed per-channel radicands; channel k at bits `[k*2W +: 2W]`.
- `s_valid`  in  `N_CH`  per-channel request.
- `s_ready`  out  `N_CH`  one-hot accept pulse.
- `core_radicand`  out  `2*INOUT_WIDTH`  radicand to the core.
- `core_i_data_valid`  out  1  core start pulse.
- `core_i_data_ready`  in  1  core idle indication.
- `core_root`  in  `INOUT_WIDTH`  core result.
- `core_o_data_valid`  in  1  core done pulse.
- `m_root`  out  `INOUT_WIDTH`  result root.
- `m_ch`  out  `$clog2(N_CH)`  channel tag for the result.
- `m_zero`  out  1  result came from a zero radicand.
- `m_timeout`  out  1  result aborted by the watchdog; stays 0 when the macro is off.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  result consumer ready.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESULT.
- **IDLE:** if any `s_valid` is set, grant the first requesting channel at or after `rr_ptr`, searching with wrap-around.
  - Pulse `s_ready[g]` for one cycle and latch the radicand and `g`.
  - Radicand == 0: set root to 0 and `m_zero` to 1, then go to RESULT. The core is not touched.
  - Radicand != 0: go to ISSUE.
- **ISSUE:** `core_radicand` is held from the latch.
  - When `core_i_data_ready` = 1, assert `core_i_data_valid` for exactly one cycle and go to WAIT.
  - Otherwise hold in ISSUE with `core_i_data_valid` = 0.
- **WAIT:** on `core_o_data_valid` = 1, capture `core_root` into `m_root` and go to RESULT.
- **RESULT:** hold `m_valid` = 1 and all `m_*` outputs stable until `m_ready` = 1.
  - On that handshake cycle: `rr_ptr` <= `g`+1, wrapping at `N_CH`, then return to IDLE.
- Only one operation is outstanding at a time; no new grant is made before the RESULT handshake completes.
- A channel dropping `s_valid` before it is granted loses nothing; that channel's request is simply not granted.
- `core_radicand` is driven from the latched value and only changes in IDLE.
- Reset values, including a reset mid-operation:
  - `s_ready` = 0, `core_i_data_valid` = 0, `core_radicand` = 0, `m_valid` = 0, `m_root` = 0, `m_ch` = 0, `m_zero` = 0, `m_timeout` = 0, `rr_ptr` = 0, state IDLE.
  - A core result arriving after reset is ignored, because it is only captured in WAIT. The core shares `resetn`, so both restart together.

## Timing
- Grant latency: `s_ready` pulses in the first IDLE cycle that sees `s_valid`.
- Nonzero path: grant, then ISSUE (≥1 cycle), then core latency (≈`2*INOUT_WIDTH`), then WAIT capture, then RESULT. `m_valid` rises the cycle after `core_o_data_valid`.
- Zero path: `m_valid` rises 1 cycle after `s_ready`.
- Back-to-back: if `m_ready` is held at 1, the next grant occurs 1 cycle after the RESULT handshake.
- Simultaneous requests: granted strictly in round-robin order starting from `rr_ptr`. No channel waits more than `N_CH`-1 operations.

## Configuration
- Macro: `RMS_SQRT_ARB_TIMEOUT_EN`.
- Defined: a cycle counter runs in ISSUE and WAIT. If it reaches `TIMEOUT_CYCLES`, the FSM goes to RESULT with `m_root` = all-ones and `m_timeout` = 1. The counter clears on entry to ISSUE.
- Undefined: no counter is built, `m_timeout` is tied to 0, and WAIT waits indefinitely.

## Structure
- Shared package `rms_pkg`:
  - FSM state enum: IDLE, ISSUE, WAIT, RESULT.
  - Default `INOUT_WIDTH`.
  - Function for the default timeout, `4*INOUT_WIDTH`.
- One sub-module: `rr_arbiter`, a combinational round-robin priority select taking `req[N_CH]` and `rr_ptr` and producing a one-hot grant plus its index.

## Test plan
- Single channel 1, radicand 144: `s_ready[1]` pulses, core started once, result `m_root` = 12, `m_ch` = 1, `m_zero` = 0.
- Channel 2, radicand 0: result in 1 cycle with `m_root` = 0 and `m_zero` = 1; `core_i_data_valid` never asserted.
- All 4 channels request simultaneously with 1, 4, 9, 16 and `rr_ptr` = 0: results arrive in `m_ch` order 0, 1, 2, 3 with roots 1, 2, 3, 4. Repeating with channels 0 and 3 only gives order 0, 3, 0, 3.
- `m_ready` held low 10 cycles in RESULT: `m_*` stable, no new `s_ready`. Releasing it gives the next grant 1 cycle later.
- Reset asserted mid-WAIT: all outputs go to reset values. A subsequent request for radicand 65025 returns 255.
- With `RMS_SQRT_ARB_TIMEOUT_EN` and the stubbed core never responding: after `TIMEOUT_CYCLES` the result has `m_timeout` = 1 and `m_root` = 0xFFFF.

Source files
------------

// File: rtl/rms_sqrt_arbiter_pkg.sv
// Shared types and defaults for the RMS square-root arbiter.
package rms_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_RESULT = 2'd3
    } arb_state_e;

    localparam int DEF_INOUT_WIDTH = 16;

    function automatic int default_timeout(input int inout_width);
        return 4 * inout_width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first requester at or after rr_ptr, with wrap-around.
module rr_arbiter #(
    parameter int N_CH = 4,
    parameter int IW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [N_CH-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_any
);

    logic [IW:0] pos_s;

    // scan N_CH positions starting at rr_ptr; the first hit wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        pos_s     = '0;
        for (int i = 0; i < N_CH; i++) begin
            pos_s = {1'b0, rr_ptr} + (IW+1)'(i);
            if (pos_s >= (IW+1)'(N_CH)) begin
                pos_s = pos_s - (IW+1)'(N_CH);
            end else begin
                pos_s = pos_s;
            end
            if (!grant_any && req[pos_s[IW-1:0]]) begin
                grant_any                = 1'b1;
                grant[pos_s[IW-1:0]]     = 1'b1;
                grant_idx                = pos_s[IW-1:0];
            end else begin
                grant_any = grant_any;
            end
        end
    end

endmodule

// File: rtl/rms_sqrt_arbiter.sv
// Shares one non_restoring_sqrt core between N_CH RMS channels, one operation at a time.
// Optional watchdog enabled by defining RMS_SQRT_ARB_TIMEOUT_EN.
module rms_sqrt_arbiter
    import rms_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int INOUT_WIDTH    = DEF_INOUT_WIDTH,
    parameter int TIMEOUT_CYCLES = default_timeout(INOUT_WIDTH)
) (
    input  logic                            aclk,
    input  logic                            resetn,
    input  logic [N_CH*2*INOUT_WIDTH-1:0]   s_radicand,
    input  logic [N_CH-1:0]                 s_valid,
    output logic [N_CH-1:0]                 s_ready,
    output logic [2*INOUT_WIDTH-1:0]        core_radicand,
    output logic                            core_i_data_valid,
    input  logic                            core_i_data_ready,
    input  logic [INOUT_WIDTH-1:0]          core_root,
    input  logic                            core_o_data_valid,
    output logic [INOUT_WIDTH-1:0]          m_root,
    output logic [$clog2(N_CH)-1:0]         m_ch,
    output logic                            m_zero,
    output logic                            m_timeout,
    output logic                            m_valid,
    input  logic                            m_ready
);

    localparam int RW = 2 * INOUT_WIDTH;
    localparam int IW = $clog2(N_CH);

    arb_state_e             state_r, state_s;
    logic [IW-1:0]          rr_ptr_r, rr_ptr_s;
    logic [IW-1:0]          ch_r, ch_s;
    logic [RW-1:0]          rad_r, rad_s;
    logic [INOUT_WIDTH-1:0] root_r, root_s;
    logic                   zero_r, zero_s;
    logic                   to_r, to_s;
    logic                   valid_r, valid_s;

    logic [N_CH-1:0]        grant_s;
    logic [IW-1:0]          grant_idx_s;
    logic                   grant_any_s;
    logic [RW-1:0]          rad_ch_s [N_CH];
    logic [RW-1:0]          sel_rad_s;
    logic                   expire_s;

    rr_arbiter #(
        .N_CH (N_CH),
        .IW   (IW)
    ) u_rr (
        .req       (s_valid),
        .rr_ptr    (rr_ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_any (grant_any_s)
    );

    // unpack the per-channel radicand bus
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            rad_ch_s[k] = s_radicand[k*RW +: RW];
        end
    end

    assign sel_rad_s = rad_ch_s[grant_idx_s];

`ifdef RMS_SQRT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_r;

    // watchdog: cleared while idle, counts every cycle the core owns the operation
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            cnt_r <= '0;
        end else if (state_r == S_IDLE) begin
            cnt_r <= '0;
        end else if (state_r == S_ISSUE || state_r == S_WAIT) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire_s = (state_r == S_ISSUE || state_r == S_WAIT) &&
                      (cnt_r == CW'(TIMEOUT_CYCLES - 1));
`else
    assign expire_s = 1'b0;
`endif

    // next-state and next-result logic
    always_comb begin
        state_s  = state_r;
        rr_ptr_s = rr_ptr_r;
        ch_s     = ch_r;
        rad_s    = rad_r;
        root_s   = root_r;
        zero_s   = zero_r;
        to_s     = to_r;
        valid_s  = valid_r;
        case (state_r)
            S_IDLE: begin
                if (grant_any_s) begin
                    ch_s  = grant_idx_s;
                    rad_s = sel_rad_s;
                    to_s  = 1'b0;
                    // the core never answers a zero radicand, so resolve it here
                    if (sel_rad_s == '0) begin
                        root_s  = '0;
                        zero_s  = 1'b1;
                        valid_s = 1'b1;
                        state_s = S_RESULT;
                    end else begin
                        zero_s  = 1'b0;
                        state_s = S_ISSUE;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (core_i_data_ready) begin
                    state_s = S_WAIT;
                end else if (expire_s) begin
                    root_s  = '1;
                    to_s    = 1'b1;
                    valid_s = 1'b1;
                    state_s = S_RESULT;
                end else begin
                    state_s = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (core_o_data_valid) begin
                    root_s  = core_root;
                    valid_s = 1'b1;
                    state_s = S_RESULT;
                end else if (expire_s) begin
                    root_s  = '1;
                    to_s    = 1'b1;
                    valid_s = 1'b1;
                    state_s = S_RESULT;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_RESULT: begin
                if (m_ready) begin
                    valid_s  = 1'b0;
                    rr_ptr_s = (ch_r == IW'(N_CH - 1)) ? '0 : ch_r + IW'(1);
                    state_s  = S_IDLE;
                end else begin
                    state_s = S_RESULT;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // state and result registers
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state_r  <= S_IDLE;
            rr_ptr_r <= '0;
            ch_r     <= '0;
            rad_r    <= '0;
            root_r   <= '0;
            zero_r   <= 1'b0;
            to_r     <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            rr_ptr_r <= rr_ptr_s;
            ch_r     <= ch_s;
            rad_r    <= rad_s;
            root_r   <= root_s;
            zero_r   <= zero_s;
            to_r     <= to_s;
            valid_r  <= valid_s;
        end
    end

    // handshake strobes follow the live inputs so a dropped request is never granted
    assign s_ready           = (resetn && state_r == S_IDLE) ? grant_s : '0;
    assign core_i_data_valid = resetn && (state_r == S_ISSUE) && core_i_data_ready;
    assign core_radicand     = rad_r;
    assign m_root            = root_r;
    assign m_ch              = ch_r;
    assign m_zero            = zero_r;
    assign m_timeout         = to_r;
    assign m_valid           = valid_r;

endmodule

// File: tb/tb_rms_sqrt_arbiter.sv
// Self-checking bench for rms_sqrt_arbiter with a behavioural sqrt core and round-robin model.
module tb_rms_sqrt_arbiter;

    localparam int N_CH = 4;
    localparam int W    = 16;
    localparam int RW   = 2 * W;
    localparam int IW   = $clog2(N_CH);
    localparam int TO   = 4 * W;

    logic                 aclk = 1'b0;
    logic                 resetn;
    logic [N_CH*RW-1:0]   s_radicand;
    logic [N_CH-1:0]      s_valid;
    logic [N_CH-1:0]      s_ready;
    logic [RW-1:0]        core_radicand;
    logic                 core_i_data_valid;
    logic                 core_i_data_ready;
    logic [W-1:0]         core_root;
    logic                 core_o_data_valid;
    logic [W-1:0]         m_root;
    logic [IW-1:0]        m_ch;
    logic                 m_zero;
    logic                 m_timeout;
    logic                 m_valid;
    logic                 m_ready;

    always #5 aclk = ~aclk;

    rms_sqrt_arbiter #(.N_CH(N_CH), .INOUT_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .aclk              (aclk),
        .resetn            (resetn),
        .s_radicand        (s_radicand),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .core_radicand     (core_radicand),
        .core_i_data_valid (core_i_data_valid),
        .core_i_data_ready (core_i_data_ready),
        .core_root         (core_root),
        .core_o_data_valid (core_o_data_valid),
        .m_root            (m_root),
        .m_ch              (m_ch),
        .m_zero            (m_zero),
        .m_timeout         (m_timeout),
        .m_valid           (m_valid),
        .m_ready           (m_ready)
    );

    int checks   = 0;
    int failures = 0;

    // requester side
    logic [RW-1:0]   req_rad [N_CH];
    logic [N_CH-1:0] req_on;
    assign s_valid = req_on;
    always_comb begin
        for (int k = 0; k < N_CH; k++) s_radicand[k*RW +: RW] = req_rad[k];
    end

    // stimulus knobs
    int p_new = 0, p_drop = 0, p_ready = 100, p_block = 0;
    int core_lat_min = 2, core_lat_max = 2 * W;
    bit core_mute = 1'b0, core_block = 1'b0;
    int core_starts = 0;

    // reference model state
    int            ptr;
    bit            busy, zero_due;
    int            exp_ch;
    logic [W-1:0]  exp_root;
    logic [RW-1:0] exp_rad;
    bit            exp_zero, exp_to;
    logic [N_CH-1:0] last_sready;
    int            res_ch[$];
    logic [W-1:0]  res_root[$];
    bit            res_to[$];

    function automatic logic [W-1:0] isqrt(input logic [RW-1:0] v);
        longint lo = 0, hi = (longint'(1) << W) - 1, mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= longint'(v)) lo = mid; else hi = mid - 1;
        end
        return W'(lo);
    endfunction

    function automatic int rr_pick(input logic [N_CH-1:0] req, input int p);
        for (int i = 0; i < N_CH; i++) begin
            if (req[(p + i) % N_CH]) return (p + i) % N_CH;
        end
        return -1;
    endfunction

    // behavioural sqrt core: random latency, silent on zero or when muted
    logic          core_idle;
    int            core_cnt;
    logic [RW-1:0] core_rad;
    assign core_i_data_ready = core_idle && !core_block;
    always @(posedge aclk) begin
        if (!resetn) begin
            core_idle <= 1'b1; core_cnt <= 0; core_rad <= '0;
            core_o_data_valid <= 1'b0; core_root <= '0;
        end else begin
            core_o_data_valid <= 1'b0;
            if (!core_idle) begin
                if (core_cnt == 0) begin
                    core_idle <= 1'b1;
                    if (core_rad != '0 && !core_mute) begin
                        core_o_data_valid <= 1'b1;
                        core_root         <= isqrt(core_rad);
                    end
                end else begin
                    core_cnt <= core_cnt - 1;
                end
            end else if (core_i_data_valid) begin
                core_idle   <= 1'b0;
                core_rad    <= core_radicand;
                core_cnt    <= $urandom_range(core_lat_max, core_lat_min);
                core_starts <= core_starts + 1;
            end
        end
    end

    function automatic logic [RW-1:0] rand_rad();
        longint v;
        case ($urandom_range(3))
            0: return '0;
            1: begin v = longint'($urandom_range(65535)); return RW'(v * v); end
            default: return RW'($urandom());
        endcase
    endfunction

    // one clock: check at negedge, then apply model updates and new stimulus after posedge
    task automatic step();
        int g; bit hs; logic [N_CH-1:0] exp_sr;
        @(negedge aclk);
        g      = busy ? -1 : rr_pick(req_on, ptr);
        exp_sr = (g < 0) ? '0 : (N_CH'(1) << g);
        last_sready = s_ready;
        checks++;
        if (s_ready !== exp_sr) begin
            failures++;
            $display("FAIL grant: s_ready=%b expected %b (ptr=%0d req=%b)", s_ready, exp_sr, ptr, req_on);
        end
        if (zero_due) begin
            checks++;
            if (m_valid !== 1'b1) begin
                failures++;
                $display("FAIL zero_latency: m_valid=%b expected 1", m_valid);
            end
            zero_due = 1'b0;
        end
        if (m_valid === 1'b1) begin
            checks++;
            if (!busy || m_root !== exp_root || m_ch !== IW'(exp_ch) || m_zero !== exp_zero || m_timeout !== exp_to) begin
                failures++;
                $display("FAIL result: busy=%0d root=%0d ch=%0d zero=%b to=%b expected root=%0d ch=%0d zero=%b to=%b",
                         busy, m_root, m_ch, m_zero, m_timeout, exp_root, exp_ch, exp_zero, exp_to);
            end
        end
        if (core_i_data_valid === 1'b1) begin
            checks++;
            if (!busy || exp_zero || core_radicand !== exp_rad || core_i_data_ready !== 1'b1) begin
                failures++;
                $display("FAIL core_start: radicand=%0d expected %0d busy=%0d zero=%0d", core_radicand, exp_rad, busy, exp_zero);
            end
        end
        hs = (m_valid === 1'b1) && (m_ready === 1'b1);
        if (hs) begin
            res_ch.push_back(int'(m_ch)); res_root.push_back(m_root); res_to.push_back(m_timeout);
        end
        @(posedge aclk); #1;
        if (hs) begin
            busy = 1'b0;
            ptr  = (exp_ch + 1) % N_CH;
        end
        if (g >= 0) begin
            busy     = 1'b1;
            exp_ch   = g;
            exp_rad  = req_rad[g];
            exp_zero = (req_rad[g] == '0);
            exp_to   = core_mute && !exp_zero;
            exp_root = exp_zero ? '0 : (core_mute ? '1 : isqrt(req_rad[g]));
            zero_due = exp_zero;
            req_on[g] = 1'b0;
        end
        for (int k = 0; k < N_CH; k++) begin
            if (!req_on[k] && $urandom_range(99) < p_new) begin
                req_rad[k] = rand_rad();
                req_on[k]  = 1'b1;
            end else if (req_on[k] && $urandom_range(99) < p_drop) begin
                req_on[k] = 1'b0;
            end
        end
        m_ready    = ($urandom_range(99) < p_ready);
        core_block = ($urandom_range(99) < p_block);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((busy || req_on != '0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (busy || req_on != '0) begin
            failures++;
            $display("FAIL drain: busy=%0d pending=%b after %0d cycles", busy, req_on, n);
        end
    endtask

    task automatic do_reset(input bit check);
        resetn = 1'b0; req_on = '0; m_ready = 1'b0; core_block = 1'b0;
        busy = 1'b0; ptr = 0; zero_due = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        if (check) begin
            checks++;
            if ({s_ready, core_i_data_valid, core_radicand, m_valid, m_root, m_ch, m_zero, m_timeout} !== '0) begin
                failures++;
                $display("FAIL reset_values: s_ready=%b civ=%b crad=%0d mv=%b root=%0d ch=%0d zero=%b to=%b expected all 0",
                         s_ready, core_i_data_valid, core_radicand, m_valid, m_root, m_ch, m_zero, m_timeout);
            end
        end
        @(posedge aclk); #1;
        resetn = 1'b1; m_ready = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
    endtask

    task automatic test_single();
        int s0 = core_starts;
        req_rad[1] = RW'(144); req_on[1] = 1'b1;
        drain(200);
        checks++;
        if (res_root.size() == 0 || res_root[$] !== W'(12) || res_ch[$] != 1 || core_starts - s0 != 1) begin
            failures++;
            $display("FAIL single: root=%0d ch=%0d starts=%0d expected root=12 ch=1 starts=1",
                     res_root.size() ? res_root[$] : W'(0), res_ch.size() ? res_ch[$] : -1, core_starts - s0);
        end
    endtask

    task automatic test_zero();
        int s0 = core_starts;
        req_rad[2] = '0; req_on[2] = 1'b1;
        drain(20);
        checks++;
        if (core_starts != s0 || res_root[$] !== W'(0) || res_ch[$] != 2) begin
            failures++;
            $display("FAIL zero: starts=%0d root=%0d ch=%0d expected starts=0 root=0 ch=2", core_starts - s0, res_root[$], res_ch[$]);
        end
    endtask

    task automatic test_all_four();
        int q[$];
        do_reset(1'b0);
        res_ch.delete();
        for (int k = 0; k < N_CH; k++) begin req_rad[k] = RW'((k + 1) * (k + 1)); req_on[k] = 1'b1; end
        drain(400);
        for (int r = 0; r < 2; r++) begin
            req_rad[0] = RW'(25); req_rad[3] = RW'(49); req_on[0] = 1'b1; req_on[3] = 1'b1;
            drain(400);
        end
        q = '{0, 1, 2, 3, 0, 3, 0, 3};
        checks++;
        if (res_ch != q) begin
            failures++;
            $display("FAIL rr_order: got %p expected %p", res_ch, q);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        p_ready = 0; m_ready = 1'b0;
        req_rad[1] = RW'(400); req_on[1] = 1'b1; req_rad[2] = '0; req_on[2] = 1'b1;
        while (m_valid !== 1'b1 && n < 200) begin step(); n++; end
        repeat (10) step();
        p_ready = 100; m_ready = 1'b1;
        step();
        step();
        checks++;
        if (last_sready !== 4'b0100) begin
            failures++;
            $display("FAIL release_grant: s_ready=%b expected 0100", last_sready);
        end
        drain(200);
    endtask

    task automatic test_reset_mid_wait();
        int n = 0, s0 = core_starts;
        core_lat_min = 50; core_lat_max = 60;
        req_rad[0] = RW'(12345678); req_on[0] = 1'b1;
        while (core_starts == s0 && n < 100) begin step(); n++; end
        repeat (5) step();
        do_reset(1'b1);
        core_lat_min = 2; core_lat_max = 2 * W;
        req_rad[3] = RW'(65025); req_on[3] = 1'b1;
        drain(200);
        checks++;
        if (res_root[$] !== W'(255) || res_ch[$] != 3) begin
            failures++;
            $display("FAIL after_reset: root=%0d ch=%0d expected root=255 ch=3", res_root[$], res_ch[$]);
        end
    endtask

    task automatic test_random();
        p_new = 30; p_drop = 5; p_ready = 70; p_block = 20;
        repeat (3000) step();
        p_new = 0; p_drop = 0; p_ready = 100; p_block = 0;
        drain(2000);
    endtask

`ifdef RMS_SQRT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        core_mute = 1'b1;
        req_rad[1] = RW'(1000); req_on[1] = 1'b1;
        drain(TO + 50);
        core_mute = 1'b0;
        checks++;
        if (res_to[$] !== 1'b1 || res_root[$] !== 16'hFFFF) begin
            failures++;
            $display("FAIL timeout: to=%b root=%h expected to=1 root=ffff", res_to[$], res_root[$]);
        end
        do_reset(1'b0);
    endtask
`endif

    initial begin
        resetn = 1'b0; m_ready = 1'b0; req_on = '0;
        for (int k = 0; k < N_CH; k++) req_rad[k] = '0;
        test_reset();
        test_single();
        test_zero();
        test_all_four();
        test_backpressure();
        test_reset_mid_wait();
        test_random();
`ifdef RMS_SQRT_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
